mac_result_commit: RTL and testbench

- Output stage placed directly downstream of the MAC rounding stage.
- Per result, it:
  - registers the rounded sign, exponent, mantissa and exception flags;
  - applies IEEE 754-2008 rounding-direction overflow saturation;
  - canonicalises NaNs;
  - packs the fields into a binary32 word.
- A 2-entry skid buffer with valid/ready handshake decouples it from the consumer.
- Flags of every committed result accumulate into a sticky RISC-V fflags register, which software can overwrite.

---
 rtl/mac_pkg.sv | 28 ++
 rtl/mac_result_commit_if.sv | 44 ++++
 rtl/mac_skid_fifo2.sv | 74 +++++++
 rtl/mac_result_commit.sv | 90 +++++++++
 tb/tb_mac_result_commit.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared constants for the MAC result commit stage.
//   Float field widths, rounding-mode encodings, canonical NaN mantissa and
//   RISC-V fflags bit positions {NV,DZ,OF,UF,NX}.
package mac_pkg;

    localparam int unsigned PARM_EXP  = 8;
    localparam int unsigned PARM_MANT = 23;
    localparam int unsigned PARM_RM   = 3;
    localparam int unsigned PARM_W    = PARM_EXP + PARM_MANT + 1;
    localparam int unsigned FLAGS_W   = 5;

    localparam logic [PARM_RM-1:0] PARM_RM_RNE = 3'b000;
    localparam logic [PARM_RM-1:0] PARM_RM_RTZ = 3'b001;
    localparam logic [PARM_RM-1:0] PARM_RM_RDN = 3'b010;
    localparam logic [PARM_RM-1:0] PARM_RM_RUP = 3'b011;
    localparam logic [PARM_RM-1:0] PARM_RM_RMM = 3'b100;

    localparam logic [PARM_MANT-1:0] PARM_MANT_NAN = 23'h400000;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef logic [FLAGS_W-1:0] fflags_t;

endpackage

// File: rtl/mac_result_commit_if.sv
// mac_result_commit_if: bus bundle for the MAC result commit stage.
//   Rounder side : in_valid/in_ready handshake plus sign, exp, mant, rounding_mode
//                  and the four raw exception flags.
//   Consumer side: out_valid/out_ready handshake plus packed result and flags.
//   Control      : flush, software fflags write (fflags_we/fflags_wdata), fflags readback.
//   modport slave  - the commit stage.
//   modport master - whatever drives the stage (rounder, consumer, CSR logic).
interface mac_result_commit_if;
    import mac_pkg::*;

    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic                 sign;
    logic [PARM_EXP-1:0]  exp;
    logic [PARM_MANT-1:0] mant;
    logic [PARM_RM-1:0]   rounding_mode;
    logic                 invalid;
    logic                 overflow;
    logic                 underflow;
    logic                 inexact;
    logic                 out_valid;
    logic                 out_ready;
    logic [PARM_W-1:0]    result;
    fflags_t              flags;
    logic                 fflags_we;
    fflags_t              fflags_wdata;
    fflags_t              fflags;

    modport slave (
        input  flush, in_valid, sign, exp, mant, rounding_mode,
               invalid, overflow, underflow, inexact, out_ready,
               fflags_we, fflags_wdata,
        output in_ready, out_valid, result, flags, fflags
    );

    modport master (
        output flush, in_valid, sign, exp, mant, rounding_mode,
               invalid, overflow, underflow, inexact, out_ready,
               fflags_we, fflags_wdata,
        input  in_ready, out_valid, result, flags, fflags
    );

endinterface

// File: rtl/mac_skid_fifo2.sv
// mac_skid_fifo2: generic 2-entry valid/ready buffer with flush.
//   clk, rst_n          - clock, synchronous active-low reset
//   flush               - invalidate both entries next cycle, drop same-cycle push
//   in_valid/in_ready   - upstream handshake; in_ready depends on state only
//   in_data [W]         - payload
//   out_valid/out_ready - downstream handshake; head entry drives out_data
//   out_data [W]        - registered head payload
module mac_skid_fifo2 #(
    parameter int unsigned W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // slot0 is always the head; slot1 only valid when slot0 is valid.
    logic [W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic         valid0_q, valid0_d, valid1_q, valid1_d;
    logic         push, pop;

    assign in_ready  = ~(valid0_q & valid1_q);
    assign out_valid = valid0_q;
    assign out_data  = slot0_q;

    always_comb begin
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        valid0_d = valid0_q;
        valid1_d = valid1_q;
        push     = in_valid & in_ready & ~flush;
        pop      = valid0_q & out_ready;

        if (flush) begin
            valid0_d = 1'b0;
            valid1_d = 1'b0;
        end else if (push && pop) begin
            // Only reachable with one entry: new data replaces the departing head.
            slot0_d = in_data;
        end else if (pop) begin
            slot0_d  = slot1_q;
            valid0_d = valid1_q;
            valid1_d = 1'b0;
        end else if (push) begin
            if (valid0_q) begin
                slot1_d  = in_data;
                valid1_d = 1'b1;
            end else begin
                slot0_d  = in_data;
                valid0_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot0_q  <= '0;
            slot1_q  <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
        end else begin
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
        end
    end

endmodule

// File: rtl/mac_result_commit.sv
// mac_result_commit: output stage after the MAC rounder.
//   clk, rst_n - clock, synchronous active-low reset
//   bus        - mac_result_commit_if.slave: rounder input handshake and fields,
//                consumer output handshake with packed binary32 result and flags,
//                flush, software fflags write and sticky fflags readback.
// Fixes up overflow saturation and NaN encoding, packs the word, buffers it in a
// 2-entry skid FIFO and accumulates committed flags into fflags.
module mac_result_commit
    import mac_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    mac_result_commit_if.slave  bus
);

    localparam logic [PARM_EXP-1:0] ExpOnes   = '1;
    localparam logic [PARM_EXP-1:0] ExpMaxFin = {{(PARM_EXP-1){1'b1}}, 1'b0};
    localparam int unsigned         PayloadW  = PARM_W + FLAGS_W;

    logic [PARM_W-1:0]   fix_result;
    fflags_t             fix_flags;
    logic                exp_ones, mant_nz, sat;
    logic [PayloadW-1:0] head;
    fflags_t             head_flags;
    logic                out_valid, commit;
    fflags_t             fflags_q, fflags_d;

    // Fix-up and packing of the incoming result.
    always_comb begin
        exp_ones = (bus.exp == ExpOnes);
        mant_nz  = |bus.mant;
        // Directed modes that round toward the finite side saturate instead of going to inf.
        sat = (bus.rounding_mode == PARM_RM_RTZ) ||
              (bus.rounding_mode == PARM_RM_RDN && !bus.sign) ||
              (bus.rounding_mode == PARM_RM_RUP &&  bus.sign);

        fix_result = {bus.sign, bus.exp, bus.mant};
        if (bus.invalid || (exp_ones && mant_nz)) begin
            fix_result = {1'b0, ExpOnes, PARM_MANT_NAN};
        end else if (bus.overflow && exp_ones && !mant_nz && sat) begin
            fix_result = {bus.sign, ExpMaxFin, {PARM_MANT{1'b1}}};
        end

        fix_flags          = '0;
        fix_flags[FLAG_NV] = bus.invalid;
        fix_flags[FLAG_DZ] = 1'b0;
        fix_flags[FLAG_OF] = bus.overflow;
        fix_flags[FLAG_UF] = bus.underflow;
        fix_flags[FLAG_NX] = bus.inexact | bus.overflow | bus.underflow;
    end

    mac_skid_fifo2 #(
        .W (PayloadW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   ({fix_result, fix_flags}),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (head)
    );

    assign head_flags    = head[FLAGS_W-1:0];
    assign bus.out_valid = out_valid;
    assign bus.result    = head[PayloadW-1:FLAGS_W];
    assign bus.flags     = head_flags;
    assign bus.fflags    = fflags_q;

    // A commit during flush still counts: the consumer already took the result.
    assign commit = out_valid & bus.out_ready;

    always_comb begin
        fflags_d = bus.fflags_we ? bus.fflags_wdata : fflags_q;
        if (commit) begin
            fflags_d = fflags_d | head_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= fflags_d;
        end
    end

endmodule

// File: tb/tb_mac_result_commit.sv
// tb_mac_result_commit: directed vector table plus hand-written multi-cycle
// sequences (backpressure, fflags write ordering, flush, mid-operation reset).
module tb_mac_result_commit;
    import mac_pkg::*;

    typedef struct {
        logic        sign;
        logic [7:0]  e;
        logic [22:0] m;
        logic [2:0]  rm;
        logic        inv, ov, uf, nx;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [4:0] ff_model;
    vec_t vecs[12];

    mac_result_commit_if bus ();

    mac_result_commit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [22:0] m,
                                input logic [2:0] rm, input logic inv, input logic ov,
                                input logic uf, input logic nx, input logic [31:0] res,
                                input logic [4:0] fl);
        vec_t v;
        v.sign = s; v.e = e; v.m = m; v.rm = rm;
        v.inv = inv; v.ov = ov; v.uf = uf; v.nx = nx;
        v.res = res; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic [7:0] e, input logic [22:0] m,
                         input logic [2:0] rm, input logic inv, input logic ov,
                         input logic uf, input logic nx);
        bus.sign = s; bus.exp = e; bus.mant = m; bus.rounding_mode = rm;
        bus.invalid = inv; bus.overflow = ov; bus.underflow = uf; bus.inexact = nx;
    endtask

    // Presents one result for a single edge; returns at the following negedge.
    task automatic push_one(input logic s, input logic [7:0] e, input logic [22:0] m,
                            input logic [2:0] rm, input logic inv, input logic ov,
                            input logic uf, input logic nx);
        drive(s, e, m, rm, inv, ov, uf, nx);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(0, 8'h7F, 23'h0,      PARM_RM_RNE, 0, 0, 0, 0, 32'h3F800000, 5'b00000);
        vecs[1]  = mk(0, 8'hFF, 23'h0,      PARM_RM_RTZ, 0, 1, 0, 0, 32'h7F7FFFFF, 5'b00101);
        vecs[2]  = mk(0, 8'hFF, 23'h0,      PARM_RM_RNE, 0, 1, 0, 0, 32'h7F800000, 5'b00101);
        vecs[3]  = mk(1, 8'hFF, 23'h0,      PARM_RM_RUP, 0, 1, 0, 0, 32'hFF7FFFFF, 5'b00101);
        vecs[4]  = mk(1, 8'h12, 23'h5,      PARM_RM_RNE, 1, 0, 0, 0, 32'h7FC00000, 5'b10000);
        vecs[5]  = mk(1, 8'hFF, 23'h1,      PARM_RM_RNE, 0, 0, 0, 0, 32'h7FC00000, 5'b00000);
        vecs[6]  = mk(1, 8'hFF, 23'h0,      PARM_RM_RDN, 0, 1, 0, 0, 32'hFF800000, 5'b00101);
        vecs[7]  = mk(0, 8'hFF, 23'h0,      PARM_RM_RDN, 0, 1, 0, 0, 32'h7F7FFFFF, 5'b00101);
        vecs[8]  = mk(1, 8'hFF, 23'h0,      PARM_RM_RMM, 0, 1, 0, 0, 32'hFF800000, 5'b00101);
        vecs[9]  = mk(0, 8'h80, 23'h123456, PARM_RM_RNE, 0, 0, 1, 1, 32'h40123456, 5'b00011);
        vecs[10] = mk(0, 8'hFF, 23'h0,      PARM_RM_RTZ, 0, 0, 0, 0, 32'h7F800000, 5'b00000);
        vecs[11] = mk(1, 8'h00, 23'h0,      PARM_RM_RNE, 0, 0, 0, 1, 32'h80000000, 5'b00001);

        rst_n = 1'b0;
        bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
        bus.fflags_we = 0; bus.fflags_wdata = '0;
        drive(0, 8'h0, 23'h0, PARM_RM_RNE, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset in_ready",  32'(bus.in_ready),  32'd1);
        chk("reset result",    bus.result,         32'h0);
        chk("reset flags",     32'(bus.flags),     32'h0);
        chk("reset fflags",    32'(bus.fflags),    32'h0);
        rst_n = 1'b1;
        ff_model = '0;

        // Table: one result at a time, consumer always ready.
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("vec%0d fflags before", i), 32'(bus.fflags), 32'(ff_model));
            push_one(vecs[i].sign, vecs[i].e, vecs[i].m, vecs[i].rm,
                     vecs[i].inv, vecs[i].ov, vecs[i].uf, vecs[i].nx);
            chk($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d result", i),    bus.result,         vecs[i].res);
            chk($sformatf("vec%0d flags", i),     32'(bus.flags),     32'(vecs[i].fl));
            ff_model = ff_model | vecs[i].fl;
            tick();
        end
        chk("table fflags final", 32'(bus.fflags),    32'h17);
        chk("table drained",      32'(bus.out_valid), 32'd0);

        // fflags: software clear, accumulate, then write ordered before commit.
        bus.fflags_we = 1; bus.fflags_wdata = 5'b11111;
        tick();
        bus.fflags_we = 0;
        chk("sw write fflags", 32'(bus.fflags), 32'h1F);
        bus.fflags_we = 1; bus.fflags_wdata = 5'b00000;
        tick();
        bus.fflags_we = 0;
        chk("sw clear fflags", 32'(bus.fflags), 32'h0);
        push_one(0, 8'h7F, 23'h0, PARM_RM_RNE, 0, 0, 1, 1);
        tick();
        push_one(0, 8'hFF, 23'h0, PARM_RM_RNE, 0, 1, 0, 0);
        tick();
        chk("fflags accumulate", 32'(bus.fflags), 32'h07);
        push_one(0, 8'h7F, 23'h0, PARM_RM_RNE, 1, 0, 0, 0);
        bus.fflags_we = 1; bus.fflags_wdata = 5'b00000;
        tick();
        bus.fflags_we = 0;
        chk("fflags write+commit", 32'(bus.fflags), 32'h10);

        // Backpressure: three results, consumer stalled.
        bus.out_ready = 0;
        drive(0, 8'h01, 23'h1, PARM_RM_RNE, 0, 0, 0, 0);
        bus.in_valid = 1;
        tick();
        chk("bp in_ready after 1", 32'(bus.in_ready), 32'd1);
        drive(0, 8'h02, 23'h2, PARM_RM_RNE, 0, 0, 0, 0);
        tick();
        chk("bp in_ready full",  32'(bus.in_ready),  32'd0);
        chk("bp out_valid",      32'(bus.out_valid), 32'd1);
        chk("bp head v1",        bus.result,         32'h00800001);
        drive(0, 8'h03, 23'h3, PARM_RM_RNE, 0, 0, 0, 0);
        tick();
        chk("bp still full",     32'(bus.in_ready),  32'd0);
        chk("bp head stable",    bus.result,         32'h00800001);
        bus.out_ready = 1;
        tick();
        chk("bp head v2",        bus.result,         32'h01000002);
        chk("bp in_ready back",  32'(bus.in_ready),  32'd1);
        tick();
        bus.in_valid = 0;
        chk("bp head v3",        bus.result,         32'h01800003);
        chk("bp v3 valid",       32'(bus.out_valid), 32'd1);
        tick();
        chk("bp drained",        32'(bus.out_valid), 32'd0);
        chk("bp fflags kept",    32'(bus.fflags),    32'h10);

        // Flush with two entries buffered.
        bus.out_ready = 0;
        push_one(0, 8'h7F, 23'h0, PARM_RM_RNE, 0, 1, 0, 0);
        push_one(0, 8'h7E, 23'h0, PARM_RM_RNE, 0, 0, 1, 0);
        chk("flush pre full", 32'(bus.in_ready), 32'd0);
        bus.flush = 1;
        tick();
        bus.flush = 0;
        chk("flush out_valid",    32'(bus.out_valid), 32'd0);
        chk("flush in_ready",     32'(bus.in_ready),  32'd1);
        chk("flush fflags kept",  32'(bus.fflags),    32'h10);

        // Flush with one entry: commit in flush cycle counts, accept is dropped.
        bus.fflags_we = 1; bus.fflags_wdata = 5'b00000;
        tick();
        bus.fflags_we = 0;
        push_one(0, 8'h7F, 23'h0, PARM_RM_RNE, 0, 0, 1, 1);
        bus.out_ready = 1; bus.flush = 1;
        drive(0, 8'h40, 23'h0, PARM_RM_RNE, 1, 0, 0, 0);
        bus.in_valid = 1;
        tick();
        bus.flush = 0; bus.in_valid = 0;
        chk("flush commit fflags", 32'(bus.fflags),    32'h03);
        chk("flush drop accept",   32'(bus.out_valid), 32'd0);
        tick();
        chk("flush still empty",   32'(bus.out_valid), 32'd0);

        // Mid-operation reset.
        bus.out_ready = 0;
        push_one(1, 8'h55, 23'h2AAAAA, PARM_RM_RNE, 0, 1, 0, 0);
        chk("pre-reset valid", 32'(bus.out_valid), 32'd1);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst result",    bus.result,         32'h0);
        chk("rst flags",     32'(bus.flags),     32'h0);
        chk("rst fflags",    32'(bus.fflags),    32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
